divider_seq: RTL and testbench

- Sequential restoring integer divider; the inverse operation of the team's CSA array multiplier.
- Computes quotient and remainder of WIDTH-bit operands, one quotient bit per clock.
- Uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath and is used to cross-check products (product / multiplicand == multiplier).

---
 rtl/divider_seq_pkg.sv | 17 +
 rtl/divider_seq_div_step.sv | 26 ++
 rtl/divider_seq.sv | 175 +++++++++++++++++
 tb/tb_divider_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package divider_seq_pkg;

  // Controller states: wait for work, iterate one quotient bit per cycle, present result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default operand width and the iteration counter width that goes with it
  localparam int DIV_WIDTH = 4;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

endpackage

// File: rtl/divider_seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract, keep or restore.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  // The shifted remainder needs one extra bit; the difference's MSB is the borrow/sign.
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_dvs};

  // Non-negative difference: keep it and emit a 1. Otherwise restore the shifted value,
  // which then must be below the divisor and therefore fits in WIDTH bits.
  assign o_qbit = ~w_diff[WIDTH];
  assign o_rem  = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider (quotient + remainder), one quotient bit per clock.
// Latency: WIDTH busy cycles then a one-cycle done pulse; divide-by-zero finishes in 1 cycle.
// Backpressure: start is only accepted in IDLE or DONE; start during RUN is ignored.
// Optional DIVIDER_SEQ_SIGNED_EN: two's-complement operands (magnitude datapath + sign fix).
module divider_seq
  import divider_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  // The package constant covers the default width; other widths derive their own.
  localparam int LCNT_W = (WIDTH == DIV_WIDTH) ? CNT_W : $clog2(WIDTH);
  localparam logic [LCNT_W-1:0] CNT_LAST = LCNT_W'(WIDTH - 1);
  localparam logic [LCNT_W-1:0] CNT_ONE  = LCNT_W'(1);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_busy;
  logic   w_done;

  logic [WIDTH-1:0]  r_rem;   // partial remainder
  logic [WIDTH-1:0]  r_dvd;   // dividend bits shift out the top, quotient bits shift in below
  logic [WIDTH-1:0]  r_dvs;
  logic [LCNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]  r_quo;
  logic [WIDTH-1:0]  r_rmd;
  logic              r_dbz;

  logic              w_accept;
  logic              w_last;
  logic              w_dvs_zero;
  logic [WIDTH-1:0]  w_rem_nxt;
  logic              w_qbit;
  logic [WIDTH-1:0]  w_quo_raw;
  logic [WIDTH-1:0]  w_quo_fix;
  logic [WIDTH-1:0]  w_rmd_fix;
  logic [WIDTH-1:0]  w_dvd_load;
  logic [WIDTH-1:0]  w_dvs_load;

  assign w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last     = (r_state == RUN) && (r_cnt == CNT_LAST);
  assign w_dvs_zero = (divisor == '0);

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[WIDTH-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  assign w_quo_raw = {r_dvd[WIDTH-2:0], w_qbit};

`ifdef DIVIDER_SEQ_SIGNED_EN
  logic r_qneg;
  logic r_rneg;

  // Divide magnitudes; the most negative value maps to its own bit pattern, which is
  // the correct unsigned magnitude 2^(WIDTH-1).
  assign w_dvd_load = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign w_dvs_load = divisor[WIDTH-1]  ? (~divisor  + 1'b1) : divisor;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign w_quo_fix  = r_qneg ? (~w_quo_raw + 1'b1) : w_quo_raw;
  assign w_rmd_fix  = r_rneg ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

  // Remember the result signs at the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
    end else if (w_accept) begin
      r_qneg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_rneg <= dividend[WIDTH-1];
    end
  end
`else
  assign w_dvd_load = dividend;
  assign w_dvs_load = divisor;
  assign w_quo_fix  = w_quo_raw;
  assign w_rmd_fix  = w_rem_nxt;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status decode
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = w_dvs_zero ? DONE : RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        if (start) begin
          w_state_nxt = w_dvs_zero ? DONE : RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, per-cycle iteration and result registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_quo <= '0;
      r_rmd <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_rem <= '0;
      r_cnt <= '0;
      r_dbz <= w_dvs_zero;
      if (w_dvs_zero) begin
        // No iterations: results land now so they are valid in the following done cycle
        r_quo <= '1;
        r_rmd <= dividend;
      end else begin
        r_dvd <= w_dvd_load;
        r_dvs <= w_dvs_load;
      end
    end else if (r_state == RUN) begin
      r_rem <= w_rem_nxt;
      r_dvd <= w_quo_raw;
      r_cnt <= r_cnt + CNT_ONE;
      if (w_last) begin
        r_quo <= w_quo_fix;
        r_rmd <= w_rmd_fix;
      end
    end
  end

  assign busy        = w_busy;
  assign done        = w_done;
  assign quotient    = r_quo;
  assign remainder   = r_rmd;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq at WIDTH=4: vector table, corner sequences, random sweep.
// Reference results come from plain integer / and % on the operands.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_divider_seq;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec;
  int n_err;

  divider_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference division straight from the arithmetic definition
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
    int sa;
    int sb;
    if (b == 0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else begin
`ifdef DIVIDER_SEQ_SIGNED_EN
      sa = $signed(a);
      sb = $signed(b);
`else
      sa = int'(a);
      sb = int'(b);
`endif
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      dz = 1'b0;
    end
  endfunction

  // Issue one division, then watch falling edges until done (bounded)
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                        output int lat, output int nbusy);
    bit seen;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat   = 0;
    nbusy = 0;
    seen  = 1'b0;
    q  = '0;
    r  = '0;
    dz = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (!seen) begin
        @(negedge clk);
        if (busy) nbusy++;
        if (done) begin
          seen = 1'b1;
          lat  = k;
          q    = quotient;
          r    = remainder;
          dz   = div_by_zero;
        end
      end
    end
  endtask

  initial begin : hard_limit
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected end by 2000000");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [W-1:0] q, r, eq, er;
    logic dz, edz;
    int lat, nbusy;
    bit seen, bad;
    logic [W-1:0] hq, hr;

    n_vec = 0;
    n_err = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

`ifdef DIVIDER_SEQ_SIGNED_EN
    tbl[0] = '{4'h9, 4'h2, 4'hD, 4'hF, 1'b0};   // -7 / 2
    tbl[1] = '{4'h7, 4'hE, 4'hD, 4'h1, 1'b0};   //  7 / -2
    tbl[2] = '{4'h8, 4'hF, 4'h8, 4'h0, 1'b0};   // -8 / -1 wraps
    tbl[3] = '{4'h9, 4'h0, 4'hF, 4'h9, 1'b1};
    tbl[4] = '{4'h7, 4'h2, 4'h3, 4'h1, 1'b0};
    tbl[5] = '{4'hF, 4'h4, 4'h0, 4'hF, 1'b0};   // -1 / 4
    tbl[6] = '{4'h8, 4'h3, 4'hE, 4'hE, 1'b0};   // -8 / 3
    tbl[7] = '{4'h7, 4'h7, 4'h1, 4'h0, 1'b0};
    tbl[8] = '{4'h6, 4'h8, 4'h0, 4'h6, 1'b0};   // 6 / -8
    tbl[9] = '{4'h0, 4'h0, 4'hF, 4'h0, 1'b1};
`else
    tbl[0] = '{4'd15, 4'd4,  4'd3,  4'd3,  1'b0};
    tbl[1] = '{4'd9,  4'd0,  4'hF,  4'd9,  1'b1};
    tbl[2] = '{4'd11, 4'd15, 4'd0,  4'd11, 1'b0};
    tbl[3] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0};
    tbl[4] = '{4'd7,  4'd2,  4'd3,  4'd1,  1'b0};
    tbl[5] = '{4'd13, 4'd5,  4'd2,  4'd3,  1'b0};
    tbl[6] = '{4'd0,  4'd7,  4'd0,  4'd0,  1'b0};
    tbl[7] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0};
    tbl[8] = '{4'd1,  4'd15, 4'd0,  4'd1,  1'b0};
    tbl[9] = '{4'd0,  4'd0,  4'hF,  4'd0,  1'b1};
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 0);
    check("reset done", 32'(done), 0);
    check("reset quotient", 32'(quotient), 0);
    check("reset remainder", 32'(remainder), 0);
    check("reset div_by_zero", 32'(div_by_zero), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Vector table: results, latency, busy length, single-cycle done
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, q, r, dz, lat, nbusy);
      check($sformatf("tbl%0d quotient", i), 32'(q), 32'(tbl[i].q));
      check($sformatf("tbl%0d remainder", i), 32'(r), 32'(tbl[i].r));
      check($sformatf("tbl%0d div_by_zero", i), 32'(dz), 32'(tbl[i].dz));
      check($sformatf("tbl%0d latency", i), 32'(lat), (tbl[i].b == 0) ? 1 : W + 1);
      check($sformatf("tbl%0d busy cycles", i), 32'(nbusy), (tbl[i].b == 0) ? 0 : W);
      @(negedge clk);
      check($sformatf("tbl%0d done pulse width", i), 32'(done), 0);
    end

    // Back-to-back: start held through DONE, second op begins with no idle gap
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd11;
    divisor  = 4'd15;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!seen) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
    end
    check("b2b first done", 32'(seen), 1);
    ref_div(4'd11, 4'd15, eq, er, edz);
    check("b2b first quotient", 32'(quotient), 32'(eq));
    check("b2b first remainder", 32'(remainder), 32'(er));
    dividend = 4'd15;
    divisor  = 4'd15;
    @(negedge clk);
    check("b2b no idle gap", 32'(busy), 1);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!seen) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
    end
    check("b2b second done", 32'(seen), 1);
    ref_div(4'd15, 4'd15, eq, er, edz);
    check("b2b second quotient", 32'(quotient), 32'(eq));
    check("b2b second remainder", 32'(remainder), 32'(er));

    // Reset pulse on the second RUN cycle aborts the operation
    run_op(4'd13, 4'd4, q, r, dz, lat, nbusy);   // leaves non-zero results behind
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd7;
    divisor  = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrun reset busy", 32'(busy), 0);
    check("midrun reset done", 32'(done), 0);
    check("midrun reset quotient", 32'(quotient), 0);
    check("midrun reset remainder", 32'(remainder), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("midrun reset no done", 32'(seen), 0);
    run_op(4'd7, 4'd2, q, r, dz, lat, nbusy);
    check("after reset quotient", 32'(q), 3);
    check("after reset remainder", 32'(r), 1);

    // start during RUN is ignored; results then hold through idle cycles
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd3;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!seen) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
    end
    check("ignore start done", 32'(seen), 1);
    ref_div(4'd13, 4'd5, eq, er, edz);
    check("ignore start quotient", 32'(quotient), 32'(eq));
    check("ignore start remainder", 32'(remainder), 32'(er));
    hq = eq;
    hr = er;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (quotient !== hq || remainder !== hr || done || busy) bad = 1'b1;
    end
    check("idle hold", 32'(bad), 0);

`ifdef DIVIDER_SEQ_SIGNED_EN
    // Exhaustive operand sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(W'(a), W'(b), q, r, dz, lat, nbusy);
        ref_div(W'(a), W'(b), eq, er, edz);
        check($sformatf("sweep %0d/%0d q", a, b), 32'(q), 32'(eq));
        check($sformatf("sweep %0d/%0d r", a, b), 32'(r), 32'(er));
        check($sformatf("sweep %0d/%0d dz", a, b), 32'(dz), 32'(edz));
      end
    end
`endif

    // Random operands against the reference model
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] a, b;
      a = W'($urandom_range(0, 15));
      b = W'($urandom_range(0, 15));
      run_op(a, b, q, r, dz, lat, nbusy);
      ref_div(a, b, eq, er, edz);
      check($sformatf("rand %0d/%0d q", a, b), 32'(q), 32'(eq));
      check($sformatf("rand %0d/%0d r", a, b), 32'(r), 32'(er));
      check($sformatf("rand %0d/%0d dz", a, b), 32'(dz), 32'(edz));
      check($sformatf("rand %0d/%0d latency", a, b), 32'(lat), (b == 0) ? 1 : W + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
